// File: rtl/sar_seq_ctrl_if.sv
// Signal bundle between the SAR sequencer and its surroundings: start
// control, comparator outputs, DAC trial code and conversion result.
interface sar_seq_ctrl_if #(
   parameter int unsigned NBITS = 10
);
   logic             start;
   logic             outp;
   logic             outn;
   logic             sample;
   logic             clkc;
   logic [NBITS-1:0] clc;
   logic [NBITS-1:0] data;
   logic             busy;
   logic             done;
   logic             meta_err;

   // sequencer side
   modport master (
      input  start, outp, outn,
      output sample, clkc, clc, data, busy, done, meta_err
   );

   // environment side (start control, comparator, DAC/datapath)
   modport slave (
      output start, outp, outn,
      input  sample, clkc, clc, data, busy, done, meta_err
   );
endinterface

// File: rtl/sar_seq_ctrl.sv
// Successive-approximation sequencer: runs the sample phase, clocks the
// comparator, resolves one bit per compare (MSB first) and publishes the
// final code with a one-cycle done pulse. All outputs are registered.
module sar_seq_ctrl #(
   parameter int unsigned NBITS      = 10,
   parameter int unsigned SAMPLE_CYC = 2,
   parameter int unsigned SETTLE_CYC = 1,
   parameter int unsigned TIMEOUT    = 8
) (
   input logic           clk,
   input logic           creset_n,
   sar_seq_ctrl_if.master bus
);

   localparam int unsigned CMAX0 = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
   localparam int unsigned CMAX  = (CMAX0 > TIMEOUT) ? CMAX0 : TIMEOUT;
   localparam int unsigned CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int unsigned IW    = (NBITS > 1) ? $clog2(NBITS) : 1;

   localparam logic [CW-1:0] SAMPLE_LAST  = CW'(SAMPLE_CYC - 1);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      SETTLE,
      COMPARE,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic             sample_r, sample_nxt;
   logic             clkc_r, clkc_nxt;
   logic [NBITS-1:0] clc_r, clc_nxt;
   logic [NBITS-1:0] data_r, data_nxt;
   logic             busy_r, busy_nxt;
   logic             done_r, done_nxt;
   logic             meta_r, meta_nxt;
   logic [IW-1:0]    idx, idx_nxt, idx_dn;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             resolve;
   logic             bitval;

   // state and registered outputs
   always_ff @(posedge clk or negedge creset_n) begin
      if (!creset_n) begin
         state    <= IDLE;
         sample_r <= 1'b0;
         clkc_r   <= 1'b0;
         clc_r    <= '0;
         data_r   <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         meta_r   <= 1'b0;
         idx      <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         sample_r <= sample_nxt;
         clkc_r   <= clkc_nxt;
         clc_r    <= clc_nxt;
         data_r   <= data_nxt;
         busy_r   <= busy_nxt;
         done_r   <= done_nxt;
         meta_r   <= meta_nxt;
         idx      <= idx_nxt;
         cnt      <= cnt_nxt;
      end
   end

   // next-state and next-output decode
   always_comb begin
      state_nxt  = state;
      sample_nxt = sample_r;
      clkc_nxt   = clkc_r;
      clc_nxt    = clc_r;
      data_nxt   = data_r;
      busy_nxt   = busy_r;
      done_nxt   = 1'b0;
      meta_nxt   = meta_r;
      idx_nxt    = idx;
      cnt_nxt    = cnt;
      idx_dn     = idx - 1'b1;
      resolve    = 1'b0;
      bitval     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt  = SAMPLE;
               sample_nxt = 1'b1;
               busy_nxt   = 1'b1;
               clc_nxt    = '0;
               meta_nxt   = 1'b0;
               idx_nxt    = IW'(NBITS - 1);
               cnt_nxt    = '0;
            end
         end
         SAMPLE: begin
            if (cnt == SAMPLE_LAST) begin
               state_nxt            = SETTLE;
               sample_nxt           = 1'b0;
               clc_nxt              = '0;
               clc_nxt[NBITS-1]     = 1'b1;
               cnt_nxt              = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SETTLE: begin
            // settle count saturates; the compare waits for a precharged comparator
            if (cnt == SETTLE_LAST) begin
               if (bus.outp && bus.outn) begin
                  state_nxt = COMPARE;
                  clkc_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         COMPARE: begin
            if ({bus.outp, bus.outn} == 2'b10) begin
               resolve = 1'b1;
               bitval  = 1'b1;
            end else if ({bus.outp, bus.outn} == 2'b01) begin
               resolve = 1'b1;
            end else if (cnt == TIMEOUT_LAST) begin
               resolve  = 1'b1;
               meta_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
            if (resolve) begin
               clc_nxt[idx] = bitval;
               clkc_nxt     = 1'b0;
               cnt_nxt      = '0;
               if (idx != '0) begin
                  clc_nxt[idx_dn] = 1'b1;
                  idx_nxt         = idx_dn;
                  state_nxt       = SETTLE;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            data_nxt  = clc_r;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.sample   = sample_r;
   assign bus.clkc     = clkc_r;
   assign bus.clc      = clc_r;
   assign bus.data     = data_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.meta_err = meta_r;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Directed bench for sar_seq_ctrl with a behavioural comparator model.
module tb_sar_seq_ctrl;

   logic clk = 1'b0;
   logic creset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [9:0] vin = '0;
   logic       stuck9 = 1'b0;
   logic       slow_pre = 1'b0;
   logic [1:0] pre_cnt = '0;

   sar_seq_ctrl_if #(.NBITS(10)) sif ();

   sar_seq_ctrl #(
      .NBITS(10),
      .SAMPLE_CYC(2),
      .SETTLE_CYC(1),
      .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .creset_n(creset_n),
      .bus(sif.master)
   );

   always #5 clk = ~clk;

   // comparator precharge delay after clkc falls (slow-precharge scenario)
   always @(posedge clk) begin
      if (slow_pre && sif.clkc) pre_cnt <= 2'd3;
      else if (pre_cnt != 2'd0) pre_cnt <= pre_cnt - 2'd1;
   end

   // comparator: decides within the evaluate cycle, precharged high otherwise
   always_comb begin
      if (sif.clkc) begin
         if (stuck9 && sif.clc == 10'h200) begin
            sif.outp = 1'b1;
            sif.outn = 1'b1;
         end else begin
            sif.outp = (vin >= sif.clc);
            sif.outn = !(vin >= sif.clc);
         end
      end else begin
         sif.outp = (pre_cnt == 2'd0);
         sif.outn = 1'b1;
      end
   end

   // present start for exactly one rising edge (edge 0)
   task automatic launch();
      @(negedge clk);
      sif.start = 1'b1;
      @(posedge clk);
      #1;
      sif.start = 1'b0;
   endtask

   // run maxcyc edges after edge 0, recording first done edge and pulse count
   task automatic run_cycles(input int maxcyc, output int first_done, output int ndone);
      first_done = 0;
      ndone = 0;
      for (int n = 1; n <= maxcyc; n++) begin
         @(posedge clk);
         #1;
         if (sif.done) begin
            ndone++;
            if (first_done == 0) first_done = n;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({sif.sample, sif.clkc, sif.busy, sif.done, sif.meta_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {sif.sample, sif.clkc, sif.busy, sif.done, sif.meta_err});
      end
      checks++;
      if (sif.clc !== 10'h000) begin
         errors++;
         $display("FAIL reset_clc: got %h expected 000", sif.clc);
      end
      checks++;
      if (sif.data !== 10'h000) begin
         errors++;
         $display("FAIL reset_data: got %h expected 000", sif.data);
      end
      repeat (3) @(negedge clk);
      creset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int fd, nd;
      int lat;
      logic s1, s2, b1, c3;
      vin = 10'h2AA;
      launch();
      lat = 0;
      fd = 0;
      nd = 0;
      s1 = 1'b0; s2 = 1'b1; b1 = 1'b0; c3 = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin s1 = sif.sample; b1 = sif.busy; end
         if (n == 2) s2 = sif.sample;
         if (n == 3) c3 = sif.clkc;
         if (sif.done) begin
            nd++;
            if (fd == 0) fd = n;
         end
      end
      checks++;
      if (s1 !== 1'b1 || s2 !== 1'b0) begin
         errors++;
         $display("FAIL sample_window: got e1=%b e2=%b expected e1=1 e2=0", s1, s2);
      end
      checks++;
      if (b1 !== 1'b1) begin
         errors++;
         $display("FAIL busy_start: got %b expected 1", b1);
      end
      checks++;
      if (c3 !== 1'b1) begin
         errors++;
         $display("FAIL clkc_first_compare: got %b expected 1", c3);
      end
      checks++;
      if (fd !== 23) begin
         errors++;
         $display("FAIL latency: got %0d expected 23", fd);
      end
      checks++;
      if (nd !== 1) begin
         errors++;
         $display("FAIL done_pulses: got %0d expected 1", nd);
      end
      checks++;
      if (sif.data !== 10'h2AA || sif.meta_err !== 1'b0 || sif.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got data=%h meta=%b busy=%b expected data=2aa meta=0 busy=0",
                  sif.data, sif.meta_err, sif.busy);
      end
   endtask

   task automatic test_extremes();
      int fd, nd;
      int badseq;
      logic [9:0] exp_clc;
      vin = 10'h3FF;
      launch();
      run_cycles(30, fd, nd);
      checks++;
      if (sif.data !== 10'h3FF || fd !== 23) begin
         errors++;
         $display("FAIL full_scale: got data=%h lat=%0d expected data=3ff lat=23", sif.data, fd);
      end
      vin = 10'h000;
      launch();
      badseq = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk);
         #1;
         if (n >= 2 && n <= 20 && (n % 2) == 0) begin
            exp_clc = 10'h200 >> ((n - 2) / 2);
            checks++;
            if (sif.clc !== exp_clc) begin
               errors++;
               $display("FAIL trial_seq: edge %0d got clc=%h expected %h", n, sif.clc, exp_clc);
            end
         end
      end
      checks++;
      if (sif.data !== 10'h000 || sif.clc !== 10'h000) begin
         errors++;
         $display("FAIL zero_scale: got data=%h clc=%h expected 000 000", sif.data, sif.clc);
      end
   endtask

   task automatic test_reset_midconv();
      int fd, nd;
      vin = 10'h155;
      launch();
      repeat (11) @(posedge clk);
      @(negedge clk);
      creset_n = 1'b0;
      #1;
      checks++;
      if ({sif.sample, sif.clkc, sif.busy, sif.done, sif.meta_err} !== 5'b0 || sif.clc !== 10'h000) begin
         errors++;
         $display("FAIL abort_outputs: got flags=%b clc=%h expected 00000 000",
                  {sif.sample, sif.clkc, sif.busy, sif.done, sif.meta_err}, sif.clc);
      end
      @(negedge clk);
      creset_n = 1'b1;
      run_cycles(40, fd, nd);
      checks++;
      if (nd !== 0 || sif.data !== 10'h000 || sif.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: got pulses=%0d data=%h busy=%b expected 0 000 0",
                  nd, sif.data, sif.busy);
      end
   endtask

   task automatic test_timeout();
      int fd, nd;
      vin = 10'h3FF;
      stuck9 = 1'b1;
      launch();
      run_cycles(45, fd, nd);
      stuck9 = 1'b0;
      checks++;
      if (fd !== 30) begin
         errors++;
         $display("FAIL timeout_latency: got %0d expected 30", fd);
      end
      checks++;
      if (sif.meta_err !== 1'b1 || sif.data !== 10'h1FF) begin
         errors++;
         $display("FAIL timeout_result: got meta=%b data=%h expected meta=1 data=1ff",
                  sif.meta_err, sif.data);
      end
   endtask

   task automatic test_start_ignored();
      int fd, nd;
      vin = 10'h1B3;
      launch();
      checks++;
      if (sif.meta_err !== 1'b0) begin
         errors++;
         $display("FAIL meta_clear: got %b expected 0", sif.meta_err);
      end
      fd = 0;
      nd = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         sif.start = (n == 15);
         @(posedge clk);
         #1;
         if (sif.done) begin
            nd++;
            if (fd == 0) fd = n;
         end
      end
      sif.start = 1'b0;
      checks++;
      if (nd !== 1 || fd !== 23 || sif.data !== 10'h1B3) begin
         errors++;
         $display("FAIL start_ignored: got pulses=%0d lat=%0d data=%h expected 1 23 1b3",
                  nd, fd, sif.data);
      end
   endtask

   task automatic test_slow_precharge();
      int fd, nd;
      vin = 10'h0F5;
      slow_pre = 1'b1;
      launch();
      run_cycles(80, fd, nd);
      slow_pre = 1'b0;
      checks++;
      if (fd !== 50 || nd !== 1) begin
         errors++;
         $display("FAIL slow_latency: got lat=%0d pulses=%0d expected 50 1", fd, nd);
      end
      checks++;
      if (sif.data !== 10'h0F5 || sif.meta_err !== 1'b0) begin
         errors++;
         $display("FAIL slow_result: got data=%h meta=%b expected 0f5 0", sif.data, sif.meta_err);
      end
   endtask

   task automatic test_back_to_back();
      int fd1, fd2, nd;
      logic b24;
      vin = 10'h2AA;
      launch();
      sif.start = 1'b1;
      fd1 = 0;
      fd2 = 0;
      nd = 0;
      b24 = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         sif.start = (n <= 30);
         @(posedge clk);
         #1;
         if (n == 24) b24 = sif.busy;
         if (sif.done) begin
            nd++;
            if (fd1 == 0) fd1 = n;
            else if (fd2 == 0) fd2 = n;
         end
      end
      sif.start = 1'b0;
      checks++;
      if (b24 !== 1'b1) begin
         errors++;
         $display("FAIL retrigger_busy: got %b expected 1", b24);
      end
      checks++;
      if (fd1 !== 23 || fd2 !== 47 || nd !== 2) begin
         errors++;
         $display("FAIL back_to_back: got first=%0d second=%0d pulses=%0d expected 23 47 2",
                  fd1, fd2, nd);
      end
      checks++;
      if (sif.data !== 10'h2AA) begin
         errors++;
         $display("FAIL b2b_data: got %h expected 2aa", sif.data);
      end
   endtask

   initial begin
      sif.start = 1'b0;
      test_reset();
      test_basic();
      test_extremes();
      test_reset_midconv();
      test_timeout();
      test_start_ignored();
      test_slow_precharge();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
